// File: rtl/regfile_probe_sequencer.sv
// ============================================================================
// Module      : regfile_probe_sequencer
// Description : Bring-up sequencer. It drives the CPU register file from the
//               board switches and push-button. A debounced press latches a
//               5-bit address and a mode, then runs either a write-then-check
//               or a plain read on the register file ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_probe_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned RD_LAT          = 1,
  parameter logic [31:0] WRITE_DATA      = 32'h0000_0015
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        switch0,
  input  logic        switch1,
  input  logic        switch2,
  input  logic        switch3,
  input  logic        button1,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] wr_data,
  output logic        wr_en,
  input  logic [31:0] rd_data1,
  input  logic [31:0] rd_data2,
  output logic [31:0] display,
  output logic        pass,
  output logic        fail,
  output logic        busy
);

  localparam int unsigned    DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]     RD_LAT_C = 4'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Synchroniser stages; button idles released (1).
  logic [1:0]      btn_sync_q;
  logic [3:0]      sw_meta_q;
  logic [3:0]      sw_sync_q;

  // Debounce state.
  logic            db_q;
  logic            db_dly_q;
  logic [DB_W-1:0] db_cnt_q;

  // Sequencer state and registered outputs.
  state_t          state_q;
  logic [4:0]      addr_q;
  logic            mode_q;
  logic [3:0]      wait_q;
  logic [4:0]      rs1_addr_q;
  logic [4:0]      rs2_addr_q;
  logic [4:0]      rd_addr_q;
  logic [31:0]     wr_data_q;
  logic            wr_en_q;
  logic [31:0]     display_q;
  logic            pass_q;
  logic            fail_q;
  logic            busy_q;

  logic            w_btn_s;
  logic            w_press;
  logic [4:0]      w_addr;
  logic [31:0]     w_exp;
  logic            w_match;

  assign w_btn_s = btn_sync_q[1];
  // Single-cycle pulse on the debounced released->pressed transition.
  assign w_press = db_dly_q & ~db_q;
  assign w_addr  = {2'b00, sw_sync_q[2:0]};
  // x0 is hardwired to zero, so a write there must read back as zero.
  assign w_exp   = (addr_q == 5'd0) ? 32'd0 : WRITE_DATA;
  assign w_match = (rd_data1 == w_exp) && (rd_data2 == w_exp);

  // Two-flop synchronisers for the asynchronous board pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_sync_q <= 2'b11;
      sw_meta_q  <= 4'd0;
      sw_sync_q  <= 4'd0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], button1};
      sw_meta_q  <= {switch3, switch2, switch1, switch0};
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      db_dly_q <= db_q;
      if (w_btn_s != db_q) begin
        if (db_cnt_q == DB_MAX) begin
          db_q     <= w_btn_s;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Sequencer FSM with registered register-file and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 5'd0;
      mode_q     <= 1'b0;
      wait_q     <= 4'd0;
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
      rd_addr_q  <= 5'd0;
      wr_data_q  <= 32'd0;
      wr_en_q    <= 1'b0;
      display_q  <= 32'd0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_press) begin
            addr_q     <= w_addr;
            mode_q     <= sw_sync_q[3];
            rs1_addr_q <= w_addr;
            rs2_addr_q <= w_addr;
            rd_addr_q  <= w_addr;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b1;
            wait_q     <= 4'd1;
            if (sw_sync_q[3] && (w_addr != 5'd0)) begin
              state_q   <= S_WRITE;
              wr_en_q   <= 1'b1;
              wr_data_q <= WRITE_DATA;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_WRITE: begin
          state_q <= S_READ;
        end
        S_READ: begin
          if (wait_q == RD_LAT_C) begin
            display_q <= rd_data1;
            if (mode_q) begin
              pass_q <= w_match;
              fail_q <= ~w_match;
            end
            state_q <= S_HOLD;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        S_HOLD: begin
          // A new sequence needs a release first.
          if (db_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rs1_addr = rs1_addr_q;
  assign rs2_addr = rs2_addr_q;
  assign rd_addr  = rd_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign display  = display_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_probe_sequencer.sv
// ============================================================================
// Module      : tb_regfile_probe_sequencer
// Description : Self-checking bench for regfile_probe_sequencer. Expected
//               results come from a per-sequence model of the press/latency
//               rules and the write/check outcome.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_probe_sequencer;

  localparam int DB     = 4;
  localparam int RDL    = 1;
  localparam logic [31:0] WDATA = 32'h0000_0015;
  // Edges from a button input change until the debounced press pulse is
  // visible: two synchroniser flops plus DB stable samples.
  localparam int PRESS_N = 2 + DB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        switch0 = 1'b0, switch1 = 1'b0, switch2 = 1'b0, switch3 = 1'b0;
  logic        button1 = 1'b1;
  logic [31:0] rd_data1 = 32'd0, rd_data2 = 32'd0;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] wr_data, display;
  logic        wr_en, pass, fail, busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  regfile_probe_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .RD_LAT(RDL),
    .WRITE_DATA(WDATA)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .switch0(switch0), .switch1(switch1), .switch2(switch2), .switch3(switch3),
    .button1(button1),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .wr_data(wr_data), .wr_en(wr_en),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .display(display), .pass(pass), .fail(fail), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rs1"},  {27'd0, rs1_addr}, 32'd0);
    check({tag, "_rs2"},  {27'd0, rs2_addr}, 32'd0);
    check({tag, "_rd"},   {27'd0, rd_addr},  32'd0);
    check({tag, "_wdat"}, wr_data,           32'd0);
    check({tag, "_wen"},  {31'd0, wr_en},    32'd0);
    check({tag, "_disp"}, display,           32'd0);
    check({tag, "_pass"}, {31'd0, pass},     32'd0);
    check({tag, "_fail"}, {31'd0, fail},     32'd0);
    check({tag, "_busy"}, {31'd0, busy},     32'd0);
  endtask

  // One complete press/hold/release sequence checked against the model.
  task automatic run_seq(input logic [3:0] sw, input logic [31:0] d1, input logic [31:0] d2,
                         input bit bounce, input int hold);
    logic [4:0]  m_addr;
    logic        m_mode, m_write, m_pass, m_fail;
    logic [31:0] m_exp;
    int          res_n, rise_n, wr_cnt, wr_at, both, busy_early, rel_n;
    logic [4:0]  wr_addr_s;
    logic [31:0] wr_data_s;
    logic        pre_pass, pre_fail;

    switch0 = sw[0]; switch1 = sw[1]; switch2 = sw[2]; switch3 = sw[3];
    rd_data1 = d1; rd_data2 = d2;
    repeat (4) tick;

    busy_early = 0;
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        button1 = (i % 2 == 1);
        repeat (2) begin
          tick;
          if (busy) busy_early++;
        end
      end
      check("bounce_no_early_start", busy_early, 0);
    end
    button1 = 1'b0;

    // Model of the expected outcome.
    m_addr  = {2'b00, sw[2:0]};
    m_mode  = sw[3];
    m_write = m_mode && (m_addr != 5'd0);
    m_exp   = (m_addr == 5'd0) ? 32'd0 : WDATA;
    m_pass  = m_mode && (d1 == m_exp) && (d2 == m_exp);
    m_fail  = m_mode && !((d1 == m_exp) && (d2 == m_exp));
    res_n   = PRESS_N + (m_write ? 2 : 1) + RDL;

    rise_n = 0; wr_cnt = 0; wr_at = 0; both = 0;
    wr_addr_s = 5'd0; wr_data_s = 32'd0; pre_pass = 1'b1; pre_fail = 1'b1;
    for (int n = 1; n <= hold; n++) begin
      tick;
      if (busy && rise_n == 0) rise_n = n;
      if (wr_en) begin
        wr_cnt++;
        wr_at = n;
        wr_addr_s = rd_addr;
        wr_data_s = wr_data;
      end
      if (pass && fail) both++;
      if (n == res_n - 1) begin
        pre_pass = pass;
        pre_fail = fail;
      end
    end

    check("busy_rise_cycle", rise_n, PRESS_N + 1);
    check("wr_en_count", wr_cnt, {31'd0, m_write});
    if (m_write) begin
      check("wr_en_cycle", wr_at, PRESS_N + 1);
      check("wr_addr", {27'd0, wr_addr_s}, {27'd0, m_addr});
      check("wr_data", wr_data_s, WDATA);
    end
    check("rs1_addr", {27'd0, rs1_addr}, {27'd0, m_addr});
    check("rs2_addr", {27'd0, rs2_addr}, {27'd0, m_addr});
    check("pass_before_result", {31'd0, pre_pass}, 32'd0);
    check("fail_before_result", {31'd0, pre_fail}, 32'd0);
    check("display", display, d1);
    check("pass", {31'd0, pass}, {31'd0, m_pass});
    check("fail", {31'd0, fail}, {31'd0, m_fail});
    check("pass_fail_exclusive", both, 0);
    check("busy_while_held", {31'd0, busy}, 32'd1);

    button1 = 1'b1;
    rel_n = 0;
    for (int n = 1; n <= 30 && rel_n == 0; n++) begin
      tick;
      if (!busy) rel_n = n;
    end
    check("busy_release_cycle", rel_n, PRESS_N + 1);
    repeat (3) tick;
  endtask

  initial begin : main
    logic [3:0]  sw;
    logic [31:0] d1, d2, e;
    int          sel, bad_wen, bad_busy, bad_pf, bad_disp;

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) tick;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick;
    check("idle_not_busy", {31'd0, busy}, 32'd0);

    // Write 0x15 to x5 and read it back correctly.
    run_seq(4'b1101, 32'h15, 32'h15, 1'b0, 40);
    // Bouncy press, then held long: exactly one sequence.
    run_seq(4'b1101, 32'h15, 32'h15, 1'b1, 120);
    // Write mode on x0: no write, expects zero.
    run_seq(4'b1000, 32'h0, 32'h0, 1'b0, 40);
    run_seq(4'b1000, 32'h15, 32'h15, 1'b0, 40);
    // Plain read of x3.
    run_seq(4'b0011, 32'hDEADBEEF, 32'h1234_5678, 1'b0, 40);

    // Randomized sequences.
    for (int k = 0; k < 8; k++) begin
      sw  = 4'($urandom);
      e   = (sw[2:0] == 3'd0) ? 32'd0 : WDATA;
      sel = $urandom_range(0, 3);
      d1  = (sel == 0 || sel == 1) ? e : $urandom;
      d2  = (sel == 0 || sel == 2) ? e : $urandom;
      run_seq(sw, d1, d2, 1'b0, 40);
    end

    // Reset while the sequencer is in READ.
    switch0 = 1'b1; switch1 = 1'b0; switch2 = 1'b1; switch3 = 1'b1;
    rd_data1 = 32'h15; rd_data2 = 32'h15;
    repeat (4) tick;
    button1 = 1'b0;
    repeat (PRESS_N + 2) tick;
    rst_n   = 1'b0;
    button1 = 1'b1;
    tick;
    check_all_zero("reset_in_read");
    rst_n = 1'b1;
    bad_wen = 0; bad_busy = 0; bad_pf = 0; bad_disp = 0;
    for (int n = 0; n < 30; n++) begin
      tick;
      if (wr_en) bad_wen++;
      if (busy) bad_busy++;
      if (pass || fail) bad_pf++;
      if (display != 32'd0) bad_disp++;
    end
    check("post_reset_no_wen", bad_wen, 0);
    check("post_reset_no_busy", bad_busy, 0);
    check("post_reset_no_result", bad_pf, 0);
    check("post_reset_display", bad_disp, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
